// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment capture path: segment patterns in
// gfedcba order, the pattern-to-code decode function and the frame FSM states.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_7_ALT = 7'h27;
    localparam logic [6:0] SEG_9_ALT = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PUBLISH
    } cap_state_t;

    // Returns {err, code}; anything unrecognised (blank included) decodes as 0 with err set.
    function automatic logic [4:0] seg_decode(input logic [6:0] pattern);
        logic [4:0] result;
        case (pattern)
            SEG_0:     result = {1'b0, 4'h0};
            SEG_1:     result = {1'b0, 4'h1};
            SEG_2:     result = {1'b0, 4'h2};
            SEG_3:     result = {1'b0, 4'h3};
            SEG_4:     result = {1'b0, 4'h4};
            SEG_5:     result = {1'b0, 4'h5};
            SEG_6:     result = {1'b0, 4'h6};
            SEG_7:     result = {1'b0, 4'h7};
            SEG_8:     result = {1'b0, 4'h8};
            SEG_9:     result = {1'b0, 4'h9};
            SEG_A:     result = {1'b0, 4'hA};
            SEG_B:     result = {1'b0, 4'hB};
            SEG_C:     result = {1'b0, 4'hC};
            SEG_D:     result = {1'b0, 4'hD};
            SEG_E:     result = {1'b0, 4'hE};
            SEG_F:     result = {1'b0, 4'hF};
            SEG_7_ALT: result = {1'b0, 4'h7};
            SEG_9_ALT: result = {1'b0, 4'h9};
            default:   result = {1'b1, 4'h0};
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational decode of one gfedcba segment pattern to a hex code plus an
// error flag for patterns outside the display table.
module seg7_pattern_decoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       err
);

    assign {err, code} = seg_decode(pattern);

endmodule

// File: rtl/seven_seg_capture.sv
// Loopback monitor for a multiplexed common-cathode 7-segment bus: filters the
// sampled segment/select lines and reassembles decoded digits into frames.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_in,
    input  logic                      dp_in,
    input  logic [NUM_DIGITS-1:0]     sel_in,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     dp_out,
    output logic [NUM_DIGITS-1:0]     digit_err,
    output logic                      frame_valid,
    output logic                      frame_timeout
);

    localparam int SW    = NUM_DIGITS + 8;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [SW-1:0]           sync1;
    logic [SW-1:0]           sync2;
    logic [SW-1:0]           s_prev;
    logic [CNT_W-1:0]        stab_cnt;
    logic                    cap_evt;
    logic                    qual;
    logic [NUM_DIGITS-1:0]   sel_norm;
    logic [3:0]              dec_code;
    logic                    dec_err;

    logic [4*NUM_DIGITS-1:0] stage_code;
    logic [NUM_DIGITS-1:0]   stage_dp;
    logic [NUM_DIGITS-1:0]   stage_err;

    cap_state_t              state;
    cap_state_t              state_next;
    logic [NUM_DIGITS-1:0]   mask;
    logic [NUM_DIGITS-1:0]   mask_next;
    logic [TO_W-1:0]         idle_cnt;
    logic [TO_W-1:0]         idle_next;
    logic                    do_publish;
    logic                    do_timeout;

    // Whole sample vector {sel, dp, seg} is synchronized together so a digit
    // change is seen as one coherent transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sel_in, dp_in, seg_in};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev   <= '0;
            stab_cnt <= '0;
        end else begin
            s_prev <= sync2;
            if (sync2 == s_prev) begin
                if (stab_cnt != CNT_W'(STABLE_CYCLES))
                    stab_cnt <= stab_cnt + 1'b1;
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    // Fires once per stable period, as the counter steps onto STABLE_CYCLES-1.
    assign cap_evt  = (sync2 == s_prev) && (stab_cnt == CNT_W'(STABLE_CYCLES - 2));
    assign sel_norm = (SEL_ACTIVE_LOW != 0) ? ~sync2[SW-1:8] : sync2[SW-1:8];
    assign qual     = cap_evt && $onehot(sel_norm);

    seg7_pattern_decoder u_decoder (
        .pattern (sync2[6:0]),
        .code    (dec_code),
        .err     (dec_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_code <= '0;
            stage_dp   <= '0;
            stage_err  <= '0;
        end else if (qual) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_norm[i]) begin
                    stage_code[4*i +: 4] <= dec_code;
                    stage_dp[i]          <= sync2[7];
                    stage_err[i]         <= dec_err;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A capture landing in the PUBLISH cycle seeds the next frame rather than being dropped.
    always_comb begin
        state_next = state;
        mask_next  = mask;
        idle_next  = idle_cnt;
        do_publish = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                idle_next = '0;
                if (qual) begin
                    mask_next  = mask | sel_norm;
                    state_next = (mask_next == '1) ? PUBLISH : COLLECT;
                end
            end
            COLLECT: begin
                if (qual) begin
                    mask_next  = mask | sel_norm;
                    idle_next  = '0;
                    state_next = (mask_next == '1) ? PUBLISH : COLLECT;
                end else if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    do_timeout = 1'b1;
                    mask_next  = '0;
                    idle_next  = '0;
                    state_next = IDLE;
                end else begin
                    idle_next = idle_cnt + 1'b1;
                end
            end
            PUBLISH: begin
                do_publish = 1'b1;
                idle_next  = '0;
                if (qual) begin
                    mask_next  = sel_norm;
                    state_next = (mask_next == '1) ? PUBLISH : COLLECT;
                end else begin
                    mask_next  = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                mask_next  = '0;
                idle_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask          <= '0;
            idle_cnt      <= '0;
            frame_valid   <= 1'b0;
            frame_timeout <= 1'b0;
            bcd_out       <= '0;
            dp_out        <= '0;
            digit_err     <= '0;
        end else begin
            mask          <= mask_next;
            idle_cnt      <= idle_next;
            frame_valid   <= do_publish;
            frame_timeout <= do_timeout;
            if (do_publish) begin
                bcd_out   <= stage_code;
                dp_out    <= stage_dp;
                digit_err <= stage_err;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: a single-digit instance for latency and
// glitch behaviour, and a four-digit instance for scans, timeout and reset.
module tb_seven_seg_capture;

    localparam int STABLE  = 16;
    localparam int DWELL   = 200;
    localparam int TIMEOUT = 1000;

    typedef struct packed {
        logic [27:0] pats;
        logic [3:0]  dp;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_err;
    } scan_vec_t;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] exp_code;
        logic       exp_dp;
        logic       exp_err;
    } single_vec_t;

    logic clk = 1'b0;
    logic rst;

    logic [6:0]  seg1;
    logic        dp1;
    logic [0:0]  sel1;
    logic [3:0]  bcd1;
    logic [0:0]  dpo1;
    logic [0:0]  err1;
    logic        fv1;
    logic        to1;

    logic [6:0]  seg4;
    logic        dp4;
    logic [3:0]  sel4;
    logic [15:0] bcd4;
    logic [3:0]  dpo4;
    logic [3:0]  err4;
    logic        fv4;
    logic        to4;

    int n_vec    = 0;
    int n_err    = 0;
    int fv1_cnt  = 0;
    int fv4_cnt  = 0;
    int to4_cnt  = 0;
    int saw8_cnt = 0;

    scan_vec_t   scan_tab [5];
    single_vec_t single_tab [5];

    always #5 clk = ~clk;

    seven_seg_capture #(
        .NUM_DIGITS     (1),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SEL_ACTIVE_LOW (1)
    ) dut1 (
        .clk           (clk),
        .rst           (rst),
        .seg_in        (seg1),
        .dp_in         (dp1),
        .sel_in        (sel1),
        .bcd_out       (bcd1),
        .dp_out        (dpo1),
        .digit_err     (err1),
        .frame_valid   (fv1),
        .frame_timeout (to1)
    );

    seven_seg_capture #(
        .NUM_DIGITS     (4),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SEL_ACTIVE_LOW (1)
    ) dut4 (
        .clk           (clk),
        .rst           (rst),
        .seg_in        (seg4),
        .dp_in         (dp4),
        .sel_in        (sel4),
        .bcd_out       (bcd4),
        .dp_out        (dpo4),
        .digit_err     (err4),
        .frame_valid   (fv4),
        .frame_timeout (to4)
    );

    always @(negedge clk) begin
        if (fv1) fv1_cnt++;
        if (fv1 && bcd1 == 4'h8) saw8_cnt++;
        if (fv4) fv4_cnt++;
        if (to4) to4_cnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [3:0] sel, input logic [6:0] seg, input logic dp, input int cycles);
        sel4 = sel;
        seg4 = seg;
        dp4  = dp;
        waitCycles(cycles);
    endtask

    task automatic applyStimulus(input scan_vec_t v);
        logic [3:0] sel;
        for (int d = 0; d < 4; d++) begin
            sel    = 4'hF;
            sel[d] = 1'b0;
            drive4(sel, v.pats[7*d +: 7], v.dp[d], DWELL);
        end
    endtask

    initial begin
        int lat;
        int fvb;
        int tob;
        int s8b;

        rst  = 1'b1;
        seg1 = 7'h00;
        dp1  = 1'b0;
        sel1 = 1'b1;
        seg4 = 7'h00;
        dp4  = 1'b0;
        sel4 = 4'hF;

        scan_tab[0] = '{pats: {7'h66, 7'h4F, 7'h5B, 7'h06}, dp: 4'b0000, exp_bcd: 16'h4321, exp_err: 4'b0000};
        scan_tab[1] = '{pats: {7'h7F, 7'h00, 7'h55, 7'h3F}, dp: 4'b0101, exp_bcd: 16'h8000, exp_err: 4'b0110};
        scan_tab[2] = '{pats: {7'h5E, 7'h39, 7'h7C, 7'h77}, dp: 4'b1111, exp_bcd: 16'hDCBA, exp_err: 4'b0000};
        scan_tab[3] = '{pats: {7'h67, 7'h27, 7'h71, 7'h79}, dp: 4'b1000, exp_bcd: 16'h97FE, exp_err: 4'b0000};
        scan_tab[4] = '{pats: {7'h6F, 7'h07, 7'h7D, 7'h6D}, dp: 4'b0010, exp_bcd: 16'h9765, exp_err: 4'b0000};

        single_tab[0] = '{seg: 7'h6D, dp: 1'b1, exp_code: 4'h5, exp_dp: 1'b1, exp_err: 1'b0};
        single_tab[1] = '{seg: 7'h12, dp: 1'b0, exp_code: 4'h0, exp_dp: 1'b0, exp_err: 1'b1};
        single_tab[2] = '{seg: 7'h27, dp: 1'b0, exp_code: 4'h7, exp_dp: 1'b0, exp_err: 1'b0};
        single_tab[3] = '{seg: 7'h71, dp: 1'b1, exp_code: 4'hF, exp_dp: 1'b1, exp_err: 1'b0};
        single_tab[4] = '{seg: 7'h3F, dp: 1'b0, exp_code: 4'h0, exp_dp: 1'b0, exp_err: 1'b0};

        waitCycles(5);
        checkOutput("reset bcd4", 32'(bcd4), 32'h0);
        checkOutput("reset dp4", 32'(dpo4), 32'h0);
        checkOutput("reset err4", 32'(err4), 32'h0);
        checkOutput("reset valid4", 32'(fv4), 32'h0);
        checkOutput("reset bcd1", 32'(bcd1), 32'h0);
        rst = 1'b0;
        waitCycles(5);

        for (int i = 0; i < 5; i++) begin
            fvb  = fv1_cnt;
            sel1 = 1'b0;
            seg1 = single_tab[i].seg;
            dp1  = single_tab[i].dp;
            lat  = -1;
            for (int n = 0; n < 40; n++) begin
                @(posedge clk);
                #1;
                if (fv1 && lat < 0) lat = n;
            end
            checkOutput($sformatf("single[%0d] latency", i), 32'(lat), 32'(STABLE + 2));
            checkOutput($sformatf("single[%0d] frames", i), 32'(fv1_cnt - fvb), 32'd1);
            checkOutput($sformatf("single[%0d] bcd", i), 32'(bcd1), 32'(single_tab[i].exp_code));
            checkOutput($sformatf("single[%0d] dp", i), 32'(dpo1), 32'(single_tab[i].exp_dp));
            checkOutput($sformatf("single[%0d] err", i), 32'(err1), 32'(single_tab[i].exp_err));
        end

        s8b  = saw8_cnt;
        fvb  = fv1_cnt;
        seg1 = 7'h7F;
        waitCycles(STABLE - 2);
        seg1 = 7'h3F;
        waitCycles(40);
        checkOutput("short glitch captured 8", 32'(saw8_cnt - s8b), 32'd0);
        checkOutput("short glitch frames", 32'(fv1_cnt - fvb), 32'd1);
        checkOutput("short glitch bcd", 32'(bcd1), 32'h0);

        s8b  = saw8_cnt;
        fvb  = fv1_cnt;
        seg1 = 7'h7F;
        waitCycles(STABLE);
        seg1 = 7'h3F;
        waitCycles(40);
        checkOutput("full-length glitch captured 8", 32'(saw8_cnt - s8b), 32'd1);
        checkOutput("full-length glitch frames", 32'(fv1_cnt - fvb), 32'd2);
        checkOutput("full-length glitch bcd", 32'(bcd1), 32'h0);

        tob = to4_cnt;
        for (int i = 0; i < 5; i++) begin
            fvb = fv4_cnt;
            applyStimulus(scan_tab[i]);
            checkOutput($sformatf("scan[%0d] frames", i), 32'(fv4_cnt - fvb), 32'd1);
            checkOutput($sformatf("scan[%0d] bcd", i), 32'(bcd4), 32'(scan_tab[i].exp_bcd));
            checkOutput($sformatf("scan[%0d] dp", i), 32'(dpo4), 32'(scan_tab[i].dp));
            checkOutput($sformatf("scan[%0d] err", i), 32'(err4), 32'(scan_tab[i].exp_err));
        end
        checkOutput("scan timeouts", 32'(to4_cnt - tob), 32'd0);

        fvb = fv4_cnt;
        tob = to4_cnt;
        drive4(4'b0011, 7'h06, 1'b0, 500);
        checkOutput("two selects frames", 32'(fv4_cnt - fvb), 32'd0);
        checkOutput("two selects timeouts", 32'(to4_cnt - tob), 32'd0);

        drive4(4'b1110, 7'h06, 1'b0, TIMEOUT + 200);
        checkOutput("stuck digit timeouts", 32'(to4_cnt - tob), 32'd1);
        checkOutput("stuck digit frames", 32'(fv4_cnt - fvb), 32'd0);
        checkOutput("stuck digit bcd held", 32'(bcd4), 32'h9765);
        checkOutput("stuck digit dp held", 32'(dpo4), 32'b0010);

        drive4(4'b1110, 7'h3F, 1'b1, DWELL);
        drive4(4'b1101, 7'h5B, 1'b0, DWELL);
        drive4(4'b1011, 7'h4F, 1'b0, DWELL);
        rst = 1'b1;
        waitCycles(3);
        checkOutput("mid-frame reset bcd4", 32'(bcd4), 32'h0);
        checkOutput("mid-frame reset dp4", 32'(dpo4), 32'h0);
        checkOutput("mid-frame reset err4", 32'(err4), 32'h0);
        checkOutput("mid-frame reset valid4", 32'(fv4), 32'h0);
        checkOutput("mid-frame reset timeout4", 32'(to4), 32'h0);
        rst = 1'b0;

        fvb = fv4_cnt;
        drive4(4'b0111, 7'h66, 1'b0, DWELL);
        checkOutput("post-reset partial frames", 32'(fv4_cnt - fvb), 32'd0);
        drive4(4'b1110, 7'h06, 1'b0, DWELL);
        drive4(4'b1101, 7'h5B, 1'b0, DWELL);
        drive4(4'b1011, 7'h4F, 1'b0, DWELL);
        checkOutput("post-reset full frames", 32'(fv4_cnt - fvb), 32'd1);
        checkOutput("post-reset bcd", 32'(bcd4), 32'h4321);
        checkOutput("post-reset err", 32'(err4), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
